// File: rtl/w_input_conditioner.sv
// Input conditioner for the two-consecutive-1s detector: synchronizes and debounces w_raw.
// It also produces one-cycle edge pulses and keeps a saturating count of aborted transitions.
module w_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_raw,
  output logic                w,
  output logic                w_rise,
  output logic                w_fall,
  output logic                stable,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_RISING  = 2'd1,
    ST_HIGH    = 2'd2,
    ST_FALLING = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync;
  logic                   w_sync;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] val);
    if (val == GLITCH_MAX) begin
      sat_inc = val;
    end else begin
      sat_inc = val + GLITCH_W'(1);
    end
  endfunction

  assign w_sync = sync[SYNC_STAGES-1];

  // Metastability chain; only its last stage feeds the debounce FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], w_raw};
    end
  end

  // Debounce FSM; w only changes after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_LOW;
      cnt        <= '0;
      w          <= 1'b0;
      w_rise     <= 1'b0;
      w_fall     <= 1'b0;
      stable     <= 1'b1;
      glitch_cnt <= '0;
    end else begin
      w_rise <= 1'b0;
      w_fall <= 1'b0;
      case (state)
        ST_LOW: begin
          if (w_sync) begin
            state  <= ST_RISING;
            cnt    <= CNT_ONE;
            stable <= 1'b0;
          end
        end
        ST_RISING: begin
          if (!w_sync) begin
            state      <= ST_LOW;
            stable     <= 1'b1;
            glitch_cnt <= sat_inc(glitch_cnt);
          end else if (cnt == CNT_LAST) begin
            state  <= ST_HIGH;
            w      <= 1'b1;
            w_rise <= 1'b1;
            stable <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!w_sync) begin
            state  <= ST_FALLING;
            cnt    <= CNT_ONE;
            stable <= 1'b0;
          end
        end
        ST_FALLING: begin
          // w stays high here so a bounce on the way down never drops it.
          if (w_sync) begin
            state      <= ST_HIGH;
            stable     <= 1'b1;
            glitch_cnt <= sat_inc(glitch_cnt);
          end else if (cnt == CNT_LAST) begin
            state  <= ST_LOW;
            w      <= 1'b0;
            w_fall <= 1'b1;
            stable <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state  <= ST_LOW;
          w      <= 1'b0;
          stable <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_w_input_conditioner.sv
// Randomized bench for w_input_conditioner against a run-length debounce model.
// A second instance with GLITCH_W=2 exercises glitch counter saturation.
module tb_w_input_conditioner;

  localparam int S = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_raw, w_raw2;
  logic       w, w_rise, w_fall, stable;
  logic [7:0] glitch_cnt;
  logic       w2, w_rise2, w_fall2, stable2;
  logic [1:0] glitch_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit m_sync [S];
  bit m_level;
  int m_run;
  int m_glitch;
  bit m_rise, m_fall;

  w_input_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .GLITCH_W(8)) dut (
    .clk(clk), .rst(rst), .w_raw(w_raw), .w(w), .w_rise(w_rise),
    .w_fall(w_fall), .stable(stable), .glitch_cnt(glitch_cnt)
  );

  w_input_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .GLITCH_W(2)) dut2 (
    .clk(clk), .rst(rst), .w_raw(w_raw2), .w(w2), .w_rise(w_rise2),
    .w_fall(w_fall2), .stable(stable2), .glitch_cnt(glitch_cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S; i++) m_sync[i] = 1'b0;
    m_level  = 1'b0;
    m_run    = 0;
    m_glitch = 0;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
  endtask

  // w follows the synchronized input once it has differed for D samples in a row;
  // a shorter differing run counts as one glitch.
  task automatic model_edge(input bit raw);
    bit samp;
    samp   = m_sync[S-1];
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (samp != m_level) begin
      m_run++;
      if (m_run == D) begin
        m_level = samp;
        m_run   = 0;
        if (samp) m_rise = 1'b1;
        else      m_fall = 1'b1;
      end
    end else begin
      if (m_run > 0 && m_glitch < 255) m_glitch++;
      m_run = 0;
    end
    for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = raw;
  endtask

  task automatic tick(input bit raw, input bit raw2);
    w_raw  = raw;
    w_raw2 = raw2;
    @(posedge clk);
    model_edge(raw);
    #1;
    check("w",          32'(w),          32'(m_level));
    check("w_rise",     32'(w_rise),     32'(m_rise));
    check("w_fall",     32'(w_fall),     32'(m_fall));
    check("stable",     32'(stable),     32'(m_run == 0));
    check("glitch_cnt", 32'(glitch_cnt), 32'(m_glitch));
  endtask

  initial begin
    int  g0;
    bit  saw_unstable;
    int  falls;
    bit  lvl;
    int  len;

    rst    = 1'b1;
    w_raw  = 1'b0;
    w_raw2 = 1'b0;
    model_reset();
    #2;
    check("rst_w",      32'(w),          32'd0);
    check("rst_w_rise", 32'(w_rise),     32'd0);
    check("rst_w_fall", 32'(w_fall),     32'd0);
    check("rst_stable", 32'(stable),     32'd1);
    check("rst_glitch", 32'(glitch_cnt), 32'd0);

    // w_raw already high through reset release: rise sequence starts from LOW
    @(posedge clk);
    @(posedge clk);
    w_raw = 1'b1;
    #3 rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick(1'b1, 1'b0);
      check("t1_w",      32'(w),      32'(k >= 6));
      check("t1_w_rise", 32'(w_rise), 32'(k == 6));
      check("t1_w_fall", 32'(w_fall), 32'd0);
    end
    check("t1_glitch", 32'(glitch_cnt), 32'd0);

    // short low bounce from HIGH
    saw_unstable = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(k > 2, 1'b0);
      check("t2_w", 32'(w), 32'd1);
      if (!stable) saw_unstable = 1'b1;
    end
    check("t2_unstable_seen", 32'(saw_unstable), 32'd1);
    check("t2_stable_end",    32'(stable),       32'd1);
    check("t2_glitch",        32'(glitch_cnt),   32'd1);

    // held low: one fall pulse after the 6th edge
    falls = 0;
    for (int k = 1; k <= 9; k++) begin
      tick(1'b0, 1'b0);
      check("t3_w",      32'(w),      32'(k < 6));
      check("t3_w_fall", 32'(w_fall), 32'(k == 6));
      if (w_fall) falls++;
    end
    check("t3_fall_count", 32'(falls), 32'd1);

    // narrow GLITCH_W instance: bursts one cycle too short
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 8; k++) begin
        tick(1'b0, k < 3);
        check("t4_w2", 32'(w2), 32'd0);
      end
      check("t4_glitch2", 32'(glitch_cnt2), 32'((b + 1 < 3) ? b + 1 : 3));
    end

    // random bouncy segments
    lvl = 1'b0;
    for (int seg = 0; seg < 150; seg++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) tick(lvl, 1'b0);
    end
    for (int k = 0; k < 200; k++) tick(1'($urandom_range(0, 1)), 1'b0);

    // async reset while RISING
    for (int k = 0; k < 10; k++) tick(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b0);
    check("t5_pre_stable", 32'(stable), 32'd0);
    g0 = 32'(glitch_cnt);
    #2 rst = 1'b1;
    #1;
    check("t5_w",      32'(w),          32'd0);
    check("t5_stable", 32'(stable),     32'd1);
    check("t5_glitch", 32'(glitch_cnt), 32'd0);
    model_reset();
    #2 rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick(1'b1, 1'b0);
      check("t5_w_after",      32'(w),      32'(k >= 6));
      check("t5_w_rise_after", 32'(w_rise), 32'(k == 6));
    end
    check("t5_glitch_after", 32'(glitch_cnt), 32'd0);
    if (g0 == 0) $display("note: no glitches accumulated before reset test");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
